// File: rtl/button_event_reader.sv
// Button front end for the Simon Says game: synchronises and debounces the
// four push-buttons, then turns each clean press into exactly one event
// delivered over a valid/ready handshake. Simultaneous presses are reported
// as a one-cycle error pulse instead of an event.
module button_event_reader #(
    parameter int DEBOUNCE_MS = 20,
    parameter int MS_CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [MS_CNT_W-1:0] ticks_per_milli,
    input  logic [3:0]          btn_raw,
    output logic [3:0]          btn_level,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [1:0]          evt_code,
    output logic                err_multi
);

    localparam int DC_W = $clog2(DEBOUNCE_MS + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PEND    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // True when exactly one bit of v is set.
    function automatic logic onehot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

    // Index of the single set bit of a one-hot vector.
    function automatic logic [1:0] enc4(input logic [3:0] v);
        logic [1:0] r;
        case (v)
            4'b0010: r = 2'd1;
            4'b0100: r = 2'd2;
            4'b1000: r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    logic [3:0]          sync1_q, sync1_d;
    logic [3:0]          sync2_q, sync2_d;
    logic [MS_CNT_W-1:0] ms_cnt_q, ms_cnt_d;
    logic [MS_CNT_W-1:0] ms_top_s;
    logic                ms_tick_s;
    logic [DC_W-1:0]     dc_q [4];
    logic [DC_W-1:0]     dc_d [4];
    logic [3:0]          level_q, level_d;
    logic [3:0]          level_prev_q, level_prev_d;
    logic [3:0]          rise_s;
    state_t              state_q, state_d;
    logic                evt_valid_q, evt_valid_d;
    logic [1:0]          evt_code_q, evt_code_d;
    logic                err_multi_q, err_multi_d;

    // Two-flop synchroniser and millisecond prescaler; a zero period is treated as one cycle.
    always_comb begin
        sync1_d   = btn_raw;
        sync2_d   = sync1_q;
        ms_top_s  = (ticks_per_milli == {MS_CNT_W{1'b0}}) ? {MS_CNT_W{1'b0}}
                                                          : ticks_per_milli - MS_CNT_W'(1);
        ms_tick_s = (ms_cnt_q >= ms_top_s);
        if (ms_tick_s) begin
            ms_cnt_d = {MS_CNT_W{1'b0}};
        end else begin
            ms_cnt_d = ms_cnt_q + MS_CNT_W'(1);
        end
    end

    // Per-button debounce: a new level is accepted only after DEBOUNCE_MS ticks without a bounce.
    always_comb begin
        level_d      = level_q;
        level_prev_d = level_q;
        for (int i = 0; i < 4; i++) begin
            dc_d[i] = dc_q[i];
            if (sync2_q[i] == level_q[i]) begin
                dc_d[i] = {DC_W{1'b0}};
            end else if (ms_tick_s) begin
                if ((dc_q[i] + DC_W'(1)) == DC_W'(DEBOUNCE_MS)) begin
                    level_d[i] = sync2_q[i];
                    dc_d[i]    = {DC_W{1'b0}};
                end else begin
                    dc_d[i] = dc_q[i] + DC_W'(1);
                end
            end else begin
                dc_d[i] = dc_q[i];
            end
        end
    end

    assign rise_s = level_q & ~level_prev_q;

    // Arbitration next state: accept a lone press, reject overlapping ones, then wait for release.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rise_s != 4'b0000) begin
                    if (onehot4(rise_s) && ((level_q & ~rise_s) == 4'b0000)) begin
                        state_d = ST_PEND;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PEND: begin
                if (evt_valid_q && evt_ready) begin
                    state_d = ST_RELEASE;
                end else begin
                    state_d = ST_PEND;
                end
            end
            ST_RELEASE: begin
                if (level_q == 4'b0000) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RELEASE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered outputs derived from the transition being taken.
    always_comb begin
        evt_valid_d = (state_d == ST_PEND);
        err_multi_d = (state_q == ST_IDLE) && (rise_s != 4'b0000) && (state_d == ST_RELEASE);
        if ((state_q == ST_IDLE) && (state_d == ST_PEND)) begin
            evt_code_d = enc4(rise_s);
        end else begin
            evt_code_d = evt_code_q;
        end
    end

    // State, output and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q      <= 4'b0000;
            sync2_q      <= 4'b0000;
            ms_cnt_q     <= {MS_CNT_W{1'b0}};
            level_q      <= 4'b0000;
            level_prev_q <= 4'b0000;
            state_q      <= ST_IDLE;
            evt_valid_q  <= 1'b0;
            evt_code_q   <= 2'd0;
            err_multi_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                dc_q[i] <= {DC_W{1'b0}};
            end
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            ms_cnt_q     <= ms_cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_prev_d;
            state_q      <= state_d;
            evt_valid_q  <= evt_valid_d;
            evt_code_q   <= evt_code_d;
            err_multi_q  <= err_multi_d;
            for (int i = 0; i < 4; i++) begin
                dc_q[i] <= dc_d[i];
            end
        end
    end

    assign btn_level = level_q;
    assign evt_valid = evt_valid_q;
    assign evt_code  = evt_code_q;
    assign err_multi = err_multi_q;

endmodule

// File: tb/tb_button_event_reader.sv
// Self-checking bench for button_event_reader: scenario table, hand-written
// corner sequences and a randomized run, all compared every cycle against a
// reference model built from run-length / tick-count arithmetic.
module tb_button_event_reader;

    localparam int DB = 3;

    logic        clk;
    logic        rst;
    logic [15:0] ticks_per_milli;
    logic [3:0]  btn_raw;
    logic [3:0]  btn_level;
    logic        evt_valid;
    logic        evt_ready;
    logic [1:0]  evt_code;
    logic        err_multi;

    button_event_reader #(.DEBOUNCE_MS(DB), .MS_CNT_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .ticks_per_milli (ticks_per_milli),
        .btn_raw         (btn_raw),
        .btn_level       (btn_level),
        .evt_valid       (evt_valid),
        .evt_ready       (evt_ready),
        .evt_code        (evt_code),
        .err_multi       (err_multi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    // Reference model state
    int          m_n;
    int          m_p;
    logic [3:0]  m_p1, m_p2;
    logic [3:0]  m_lvl, m_lvl_prev;
    int          m_run [4];
    logic        m_pend, m_wait, m_err;
    logic [1:0]  m_code;

    // Observed tallies
    int          ev_count, err_count;
    logic [1:0]  last_code;
    logic        prev_valid;

    typedef struct {
        int         tpm;
        logic [3:0] pins;
        int         hold;
        int         exp_events;
        int         exp_code;
        int         exp_errs;
    } vec_t;

    vec_t tbl [8];

    function automatic int popc(input logic [3:0] v);
        int c = 0;
        for (int i = 0; i < 4; i++) if (v[i]) c++;
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int tpm);
        m_n = 0;
        m_p = (tpm == 0) ? 1 : tpm;
        m_p1 = 4'b0000; m_p2 = 4'b0000;
        m_lvl = 4'b0000; m_lvl_prev = 4'b0000;
        for (int i = 0; i < 4; i++) m_run[i] = -1;
        m_pend = 1'b0; m_wait = 1'b0; m_err = 1'b0; m_code = 2'd0;
        ev_count = 0; err_count = 0; last_code = 2'd0; prev_valid = 1'b0;
    endtask

    // One clock edge of the model. A level is accepted once the current run of
    // disagreeing samples has spanned DB millisecond ticks; ticks fall on edges
    // n with n mod P == P-1, so the ticks in edges r..n are (n+1)/P - r/P.
    task automatic model_edge(input logic [3:0] pins, input logic rdy);
        logic [3:0] rise;
        logic [3:0] nl;
        int t;
        rise  = m_lvl & ~m_lvl_prev;
        m_err = 1'b0;
        if (m_pend) begin
            if (rdy) begin m_pend = 1'b0; m_wait = 1'b1; end
        end else if (m_wait) begin
            if (m_lvl == 4'b0000) m_wait = 1'b0;
        end else if (rise != 4'b0000) begin
            if (popc(rise) == 1 && (m_lvl & ~rise) == 4'b0000) begin
                m_pend = 1'b1;
                for (int i = 0; i < 4; i++) if (rise[i]) m_code = 2'(i);
            end else begin
                m_err = 1'b1; m_wait = 1'b1;
            end
        end
        nl = m_lvl;
        for (int i = 0; i < 4; i++) begin
            if (m_p2[i] == m_lvl[i]) begin
                m_run[i] = -1;
            end else begin
                if (m_run[i] < 0) m_run[i] = m_n;
                t = (m_n + 1) / m_p - m_run[i] / m_p;
                if (t >= DB) begin nl[i] = m_p2[i]; m_run[i] = -1; end
            end
        end
        m_lvl_prev = m_lvl;
        m_lvl      = nl;
        m_p2       = m_p1;
        m_p1       = pins;
        m_n++;
    endtask

    task automatic compare_all();
        chk("btn_level", btn_level, m_lvl);
        chk("evt_valid", evt_valid, m_pend);
        if (m_pend) chk("evt_code", evt_code, m_code);
        chk("err_multi", err_multi, m_err);
        if (evt_valid && !prev_valid) begin ev_count++; last_code = evt_code; end
        if (err_multi) err_count++;
        prev_valid = evt_valid;
    endtask

    // Drive inputs at the falling edge, clock once, check at the next falling edge.
    task automatic cycle(input logic [3:0] pins, input logic rdy);
        btn_raw   = pins;
        evt_ready = rdy;
        @(posedge clk);
        model_edge(pins, rdy);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset(input int tpm);
        rst = 1'b0;
        ticks_per_milli = 16'(tpm);
        repeat (2) @(negedge clk);
        model_reset(tpm);
        compare_all();
        rst = 1'b1;
    endtask

    task automatic wait_valid(input logic [3:0] pins, input string name);
        int w = 0;
        while (!evt_valid && w < 80) begin cycle(pins, 1'b0); w++; end
        chk(name, evt_valid, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rp;
        int hold;
        int r;

        tbl[0] = '{4, 4'b0100, 40, 1, 2, 0};
        tbl[1] = '{4, 4'b0001, 40, 1, 0, 0};
        tbl[2] = '{4, 4'b1000, 40, 1, 3, 0};
        tbl[3] = '{4, 4'b1001, 40, 0, 0, 1};
        tbl[4] = '{4, 4'b0110, 40, 0, 0, 1};
        tbl[5] = '{4, 4'b0010,  5, 0, 0, 0};
        tbl[6] = '{0, 4'b0100, 10, 1, 2, 0};
        tbl[7] = '{1, 4'b1000, 12, 1, 3, 0};

        rst = 1'b0; btn_raw = 4'b0000; evt_ready = 1'b0; ticks_per_milli = 16'd4;
        @(negedge clk);

        // Scenario table
        for (int k = 0; k < 8; k++) begin
            do_reset(tbl[k].tpm);
            chk("tbl_reset_level", btn_level, 4'b0000);
            chk("tbl_reset_valid", evt_valid, 1'b0);
            repeat (tbl[k].hold) cycle(tbl[k].pins, 1'b1);
            repeat (40) cycle(4'b0000, 1'b1);
            chk("tbl_events", ev_count, tbl[k].exp_events);
            if (tbl[k].exp_events > 0) chk("tbl_code", last_code, tbl[k].exp_code);
            chk("tbl_errs", err_count, tbl[k].exp_errs);
        end

        // BTN1 bouncing, then held
        do_reset(4);
        for (int c = 0; c < 30; c++) begin
            cycle(((c / 3) % 2) != 0 ? 4'b0010 : 4'b0000, 1'b1);
            chk("bounce_level", btn_level[1], 1'b0);
        end
        repeat (30) cycle(4'b0010, 1'b1);
        repeat (30) cycle(4'b0000, 1'b1);
        chk("bounce_events", ev_count, 1);
        chk("bounce_code", last_code, 2'd1);

        // Simultaneous BTN0+BTN3, then BTN3 alone
        do_reset(4);
        repeat (30) cycle(4'b1001, 1'b1);
        repeat (30) cycle(4'b0000, 1'b1);
        chk("multi_errs", err_count, 1);
        chk("multi_events", ev_count, 0);
        repeat (30) cycle(4'b1000, 1'b1);
        repeat (30) cycle(4'b0000, 1'b1);
        chk("multi_then_events", ev_count, 1);
        chk("multi_then_code", last_code, 2'd3);

        // Consumer stalled while another button is pressed
        do_reset(4);
        wait_valid(4'b0001, "stall_wait_valid");
        for (int c = 0; c < 50; c++) begin
            cycle(c < 10 ? 4'b0001 : (c < 25 ? 4'b0000 : 4'b0100), 1'b0);
            chk("stall_valid", evt_valid, 1'b1);
            chk("stall_code", evt_code, 2'd0);
        end
        cycle(4'b0100, 1'b1);
        chk("stall_drop", evt_valid, 1'b0);
        repeat (10) cycle(4'b0100, 1'b1);
        repeat (40) cycle(4'b0000, 1'b1);
        chk("stall_events", ev_count, 1);

        // Asynchronous reset while an event is pending; button held through it
        do_reset(4);
        wait_valid(4'b0010, "rst_wait_valid");
        #2;
        rst = 1'b0;
        #1;
        chk("async_valid", evt_valid, 1'b0);
        chk("async_level", btn_level, 4'b0000);
        chk("async_code", evt_code, 2'd0);
        chk("async_err", err_multi, 1'b0);
        @(negedge clk);
        @(negedge clk);
        model_reset(4);
        rst = 1'b1;
        repeat (40) cycle(4'b0010, 1'b1);
        chk("held_events", ev_count, 1);
        chk("held_code", last_code, 2'd1);
        repeat (30) cycle(4'b0000, 1'b1);

        // Zero period: every cycle is a millisecond tick
        do_reset(0);
        for (int k = 1; k <= 8; k++) begin
            cycle(4'b0100, 1'b1);
            if (k == 4) chk("tpm0_level_before", btn_level, 4'b0000);
            if (k == 5) chk("tpm0_level_at", btn_level, 4'b0100);
            if (k == 5) chk("tpm0_valid_before", evt_valid, 1'b0);
            if (k == 6) chk("tpm0_valid_at", evt_valid, 1'b1);
            if (k == 6) chk("tpm0_code", evt_code, 2'd2);
        end
        repeat (20) cycle(4'b0000, 1'b1);

        // Randomized stimulus against the model
        for (int blk = 0; blk < 6; blk++) begin
            do_reset(int'($urandom_range(0, 5)));
            hold = 0;
            rp = 4'b0000;
            for (int c = 0; c < 400; c++) begin
                if (hold == 0) begin
                    r = int'($urandom_range(0, 9));
                    if (r < 4)       rp = 4'b0000;
                    else if (r < 8)  rp = 4'(1 << (r - 4));
                    else if (r == 8) rp = 4'(1 << $urandom_range(0, 3)) | 4'(1 << $urandom_range(0, 3));
                    else             rp = 4'($urandom_range(0, 15));
                    hold = int'($urandom_range(1, 25));
                end
                hold--;
                cycle(rp, $urandom_range(0, 3) != 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
